// File: rtl/mux_nway_rr_if.sv
// Stream bundle for mux_nway_rr: N valid/ready producer channels, mode/select
// controls, and one registered valid/ready consumer port.
interface mux_nway_rr_if #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int SELW  = $clog2(N)
);
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;

    // Master drives producers, controls and consumer ready; slave is the mux.
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_nway_rr.sv
// N-channel registered stream multiplexer with external-select or round-robin
// channel choice; the accepted word is held in a one-deep register with its index.
module mux_nway_rr #(
    parameter  int WIDTH = 16,
    parameter  int N     = 8,
    localparam int SELW  = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    mux_nway_rr_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } occ_e;

    occ_e             state_q, state_d;
    logic [WIDTH-1:0] outData_q, outData_d;
    logic [SELW-1:0]  outChan_q, outChan_d;
    logic [SELW-1:0]  rrPtr_q, rrPtr_d;

    logic             loadOk;
    logic             selInRange;
    logic             rrFound;
    logic [SELW-1:0]  rrGrant;
    logic [SELW-1:0]  scanIdx;
    logic             grantValid;
    logic [SELW-1:0]  grant;
    logic             grantInValid;
    logic [WIDTH-1:0] grantData;
    logic             transfer;

    // Channel at distance offs past base, wrapped modulo N (N need not be a power of two).
    function automatic logic [SELW-1:0] wrapIdx(input logic [SELW-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= N) begin
            sum = sum - N;
        end
        return sum[SELW-1:0];
    endfunction

    assign selInRange = int'(bus.sel) < N;
    assign loadOk     = (state_q == EMPTY) || bus.out_ready;

    always_comb begin
        rrFound = 1'b0;
        rrGrant = '0;
        scanIdx = '0;
        for (int i = 0; i < N; i++) begin
            scanIdx = wrapIdx(rrPtr_q, i);
            if (!rrFound && bus.in_valid[scanIdx]) begin
                rrFound = 1'b1;
                rrGrant = scanIdx;
            end
        end
    end

    always_comb begin
        grantValid = 1'b0;
        grant      = '0;
        if (bus.mode) begin
            grantValid = rrFound;
            grant      = rrGrant;
        end else begin
            grantValid = selInRange;
            grant      = bus.sel;
        end
    end

    // A one-hot decode avoids an out-of-range part-select when sel >= N.
    always_comb begin
        bus.in_ready = '0;
        grantInValid = 1'b0;
        grantData    = '0;
        for (int k = 0; k < N; k++) begin
            if (grantValid && (int'(grant) == k)) begin
                bus.in_ready[k] = reset_n && loadOk;
                grantInValid    = bus.in_valid[k];
                grantData       = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign transfer = grantValid && grantInValid && loadOk && reset_n;

    always_comb begin
        state_d   = state_q;
        outData_d = outData_q;
        outChan_d = outChan_q;
        rrPtr_d   = rrPtr_q;

        case (state_q)
            EMPTY: begin
                if (transfer) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (bus.out_ready && !transfer) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (transfer) begin
            outData_d = grantData;
            outChan_d = grant;
            if (bus.mode) begin
                rrPtr_d = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            outData_q <= '0;
            outChan_q <= '0;
            rrPtr_q   <= '0;
        end else begin
            state_q   <= state_d;
            outData_q <= outData_d;
            outChan_q <= outChan_d;
            rrPtr_q   <= rrPtr_d;
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = outData_q;
    assign bus.out_chan  = outChan_q;

endmodule

// File: tb/tb_mux_nway_rr.sv
// Scoreboard bench for mux_nway_rr: an 8-channel instance for the main
// scenarios and a 6-channel instance for out-of-range select handling.
module tb_mux_nway_rr;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    mux_nway_rr_if #(.WIDTH(16), .N(8)) bus8 ();
    mux_nway_rr_if #(.WIDTH(16), .N(6)) bus6 ();

    mux_nway_rr #(.WIDTH(16), .N(8)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8.slave)
    );

    mux_nway_rr #(.WIDTH(16), .N(6)) dut6 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus6.slave)
    );

    typedef struct packed {
        logic [2:0]  chan;
        logic [15:0] data;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    // Word base+k on every channel of the 8-way instance.
    task automatic fillData8(input logic [15:0] base);
        for (int k = 0; k < 8; k++) begin
            bus8.in_data[k*16 +: 16] = base + 16'(k);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [2:0] s, input logic [7:0] v, input logic ordy);
        bus8.mode      = m;
        bus8.sel       = s;
        bus8.in_valid  = v;
        bus8.out_ready = ordy;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        applyStimulus(1'b0, 3'd0, 8'hFF, 1'b1);
        fillData8(16'h0100);
        bus6.mode = 1'b0; bus6.sel = '0; bus6.in_valid = '0; bus6.in_data = '0; bus6.out_ready = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_out_valid got %b want 0", bus8.out_valid);
        end
        checks++;
        if (bus8.out_data !== 16'h0000) begin
            failures++; $display("[TB] FAIL reset_out_data got %h want 0000", bus8.out_data);
        end
        checks++;
        if (bus8.out_chan !== 3'd0) begin
            failures++; $display("[TB] FAIL reset_out_chan got %0d want 0", bus8.out_chan);
        end
        checks++;
        if (bus8.in_ready !== 8'h00) begin
            failures++; $display("[TB] FAIL reset_in_ready got %h want 00", bus8.in_ready);
        end
        @(negedge clk);
        bus8.in_valid = 8'h00;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL idle_out_valid got %b want 0", bus8.out_valid);
        end
        checks++;
        if (bus8.in_ready !== 8'h01) begin
            failures++; $display("[TB] FAIL idle_in_ready got %h want 01", bus8.in_ready);
        end
    endtask

    task automatic test_select();
        exp_t e;
        @(posedge clk); #2;
        fillData8(16'h1000);
        bus8.in_data[5*16 +: 16] = 16'hA5A5;
        applyStimulus(1'b0, 3'd5, 8'hFF, 1'b1);
        #1;
        checks++;
        if (bus8.in_ready !== 8'h20) begin
            failures++; $display("[TB] FAIL sel_in_ready got %h want 20", bus8.in_ready);
        end
        expQ.push_back('{chan: 3'd5, data: 16'hA5A5});
        @(posedge clk); #2;
        bus8.in_valid = 8'h00;
        @(negedge clk);
        checks++;
        if (bus8.out_valid !== 1'b1 || expQ.size() == 0) begin
            failures++; $display("[TB] FAIL sel_out_valid got %b want 1", bus8.out_valid);
        end else begin
            e = expQ.pop_front();
            checks++;
            if (bus8.out_data !== e.data || bus8.out_chan !== e.chan) begin
                failures++; $display("[TB] FAIL sel_word got %h/%0d want %h/%0d", bus8.out_data, bus8.out_chan, e.data, e.chan);
            end
        end
        @(negedge clk);
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.out_data !== 16'hA5A5 || bus8.out_chan !== 3'd5) begin
            failures++; $display("[TB] FAIL drain_hold got %b/%h/%0d want 0/a5a5/5", bus8.out_valid, bus8.out_data, bus8.out_chan);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        @(posedge clk); #2;
        fillData8(16'hC000);
        applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
        for (int i = 0; i < 10; i++) begin
            expQ.push_back('{chan: 3'(i % 8), data: 16'hC000 + 16'(i % 8)});
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (i == 9) bus8.in_valid = 8'h00;
            @(negedge clk);
            checks++;
            if (bus8.out_valid !== 1'b1 || expQ.size() == 0) begin
                failures++; $display("[TB] FAIL rr_valid%0d got %b want 1", i, bus8.out_valid);
            end else begin
                e = expQ.pop_front();
                if (bus8.out_chan !== e.chan || bus8.out_data !== e.data) begin
                    failures++; $display("[TB] FAIL rr_word%0d got %h/%0d want %h/%0d", i, bus8.out_data, bus8.out_chan, e.data, e.chan);
                end
            end
        end
    endtask

    task automatic test_wrap();
        exp_t        e;
        logic [7:0]  rdyExp [3];
        logic [2:0]  chanExp[3];
        rdyExp  = '{8'h80, 8'h02, 8'h80};
        chanExp = '{3'd7, 3'd1, 3'd7};
        @(posedge clk); #2;
        fillData8(16'h0000);
        bus8.in_data[7*16 +: 16] = 16'h7777;
        bus8.in_data[1*16 +: 16] = 16'h1111;
        applyStimulus(1'b1, 3'd0, 8'b1000_0010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus8.in_ready !== rdyExp[i]) begin
                failures++; $display("[TB] FAIL wrap_ready%0d got %h want %h", i, bus8.in_ready, rdyExp[i]);
            end
            expQ.push_back('{chan: chanExp[i], data: (chanExp[i] == 3'd7) ? 16'h7777 : 16'h1111});
            @(posedge clk); #2;
            if (i == 2) bus8.in_valid = 8'h00;
            @(negedge clk);
            checks++;
            if (bus8.out_valid !== 1'b1 || expQ.size() == 0) begin
                failures++; $display("[TB] FAIL wrap_valid%0d got %b want 1", i, bus8.out_valid);
            end else begin
                e = expQ.pop_front();
                if (bus8.out_chan !== e.chan || bus8.out_data !== e.data) begin
                    failures++; $display("[TB] FAIL wrap_word%0d got %h/%0d want %h/%0d", i, bus8.out_data, bus8.out_chan, e.data, e.chan);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(posedge clk); #2;
        fillData8(16'h0000);
        bus8.in_data[3*16 +: 16] = 16'h3333;
        applyStimulus(1'b0, 3'd3, 8'h08, 1'b1);
        #1;
        checks++;
        if (bus8.in_ready !== 8'h08) begin
            failures++; $display("[TB] FAIL bp_first_ready got %h want 08", bus8.in_ready);
        end
        expQ.push_back('{chan: 3'd3, data: 16'h3333});
        @(posedge clk); #2;
        bus8.in_data[4*16 +: 16] = 16'h4444;
        applyStimulus(1'b0, 3'd4, 8'h10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (expQ.size() == 0 || bus8.out_valid !== 1'b1 || bus8.out_data !== expQ[0].data
                || bus8.out_chan !== expQ[0].chan || bus8.in_ready !== 8'h00) begin
                failures++; $display("[TB] FAIL bp_hold%0d got %b/%h/%0d rdy %h want 1/3333/3 rdy 00", i, bus8.out_valid, bus8.out_data, bus8.out_chan, bus8.in_ready);
            end
        end
        @(posedge clk); #2;
        bus8.out_ready = 1'b1;
        #1;
        checks++;
        if (bus8.in_ready !== 8'h10) begin
            failures++; $display("[TB] FAIL bp_release_ready got %h want 10", bus8.in_ready);
        end
        expQ.push_back('{chan: 3'd4, data: 16'h4444});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus8.out_valid !== 1'b1 || expQ.size() == 0) begin
                failures++; $display("[TB] FAIL b2b_valid%0d got %b want 1", i, bus8.out_valid);
            end else begin
                e = expQ.pop_front();
                if (bus8.out_chan !== e.chan || bus8.out_data !== e.data) begin
                    failures++; $display("[TB] FAIL b2b_word%0d got %h/%0d want %h/%0d", i, bus8.out_data, bus8.out_chan, e.data, e.chan);
                end
            end
            if (i == 0) begin
                @(posedge clk); #2;
                bus8.in_valid = 8'h00;
            end
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        @(posedge clk); #2;
        fillData8(16'h6000);
        applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
        expQ.push_back('{chan: 3'd0, data: 16'h6000});
        expQ.push_back('{chan: 3'd1, data: 16'h6001});
        @(posedge clk); #2;
        @(negedge clk);
        checks++;
        if (bus8.out_valid !== 1'b1 || expQ.size() == 0) begin
            failures++; $display("[TB] FAIL mid_first_valid got %b want 1", bus8.out_valid);
        end else begin
            e = expQ.pop_front();
            if (bus8.out_chan !== e.chan || bus8.out_data !== e.data) begin
                failures++; $display("[TB] FAIL mid_first_word got %h/%0d want %h/%0d", bus8.out_data, bus8.out_chan, e.data, e.chan);
            end
        end
        @(posedge clk); #2;
        bus8.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus8.out_valid !== 1'b1 || bus8.out_chan !== 3'd1) begin
            failures++; $display("[TB] FAIL mid_held got %b/%0d want 1/1", bus8.out_valid, bus8.out_chan);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.out_chan !== 3'd0 || bus8.out_data !== 16'h0000 || bus8.in_ready !== 8'h00) begin
            failures++; $display("[TB] FAIL async_reset got %b/%0d/%h rdy %h want 0/0/0000 rdy 00", bus8.out_valid, bus8.out_chan, bus8.out_data, bus8.in_ready);
        end
        expQ.delete();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus8.in_ready !== 8'h01) begin
            failures++; $display("[TB] FAIL rr_ptr_after_reset ready got %h want 01", bus8.in_ready);
        end
        bus8.in_valid = 8'h00;
    endtask

    task automatic test_bad_sel();
        exp_t e;
        @(posedge clk); #2;
        for (int k = 0; k < 6; k++) begin
            bus6.in_data[k*16 +: 16] = 16'h5000 + 16'(k);
        end
        bus6.in_data[5*16 +: 16] = 16'h6666;
        bus6.mode = 1'b0; bus6.sel = 3'd7; bus6.in_valid = 6'h3F; bus6.out_ready = 1'b1;
        #1;
        checks++;
        if (bus6.in_ready !== 6'h00) begin
            failures++; $display("[TB] FAIL badsel_ready got %h want 00", bus6.in_ready);
        end
        @(posedge clk); #2;
        @(negedge clk);
        checks++;
        if (bus6.out_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL badsel_no_transfer got %b want 0", bus6.out_valid);
        end
        @(posedge clk); #2;
        bus6.sel = 3'd5;
        #1;
        checks++;
        if (bus6.in_ready !== 6'h20) begin
            failures++; $display("[TB] FAIL top_sel_ready got %h want 20", bus6.in_ready);
        end
        expQ.push_back('{chan: 3'd5, data: 16'h6666});
        @(posedge clk); #2;
        bus6.in_valid = 6'h00;
        @(negedge clk);
        checks++;
        if (bus6.out_valid !== 1'b1 || expQ.size() == 0) begin
            failures++; $display("[TB] FAIL top_sel_valid got %b want 1", bus6.out_valid);
        end else begin
            e = expQ.pop_front();
            if (bus6.out_chan !== e.chan || bus6.out_data !== e.data) begin
                failures++; $display("[TB] FAIL top_sel_word got %h/%0d want %h/%0d", bus6.out_data, bus6.out_chan, e.data, e.chan);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_select();
        test_round_robin();
        test_wrap();
        test_back_to_back();
        test_reset_midstream();
        test_bad_sel();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
